// File: rtl/mem_burst_ram.sv
`default_nettype none
// ============================================================================
// mem_burst_ram : byte-lane RAM with independent read and write burst engines
// Revision 1.0
// ============================================================================
module mem_burst_ram #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 7,
    parameter int LEN_W      = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    W_START,
    input  logic [ADDR_W-1:0]       W_ADDR,
    input  logic [LEN_W-1:0]        W_LEN,
    input  logic [1:0]              W_BURST,
    input  logic                    W_VALID,
    input  logic [8*DATA_BYTES-1:0] W_DATA,
    input  logic [DATA_BYTES-1:0]   W_STRB,
    output logic                    W_READY,
    output logic                    W_BUSY,
    output logic                    W_DONE,
    input  logic                    R_START,
    input  logic [ADDR_W-1:0]       R_ADDR,
    input  logic [LEN_W-1:0]        R_LEN,
    input  logic [1:0]              R_BURST,
    input  logic                    R_READY,
    output logic [8*DATA_BYTES-1:0] R_DATA,
    output logic                    R_VALID,
    output logic                    R_LAST,
    output logic                    R_BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] WS_IDLE  = 2'd0;
    localparam logic [1:0] WS_DATA  = 2'd1;
    localparam logic [1:0] WS_RESP  = 2'd2;
    localparam logic [1:0] RS_IDLE  = 2'd0;
    localparam logic [1:0] RS_FETCH = 2'd1;
    localparam logic [1:0] RS_OUT   = 2'd2;

    logic [7:0] mem [DEPTH];

    // WRAP windows are power-of-two sized, so the mask also covers windows
    // larger than the memory (truncation yields all ones).
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [LEN_W-1:0]  len,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        logic              wrap_ok;
        inc     = a + ADDR_W'(DATA_BYTES);
        mask    = ADDR_W'((int'(len) + 1) * DATA_BYTES - 1);
        wrap_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
        if (burst == 2'd0)
            return a;
        else if (burst == 2'd2 && wrap_ok)
            return (a & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    // ---------------- write engine ----------------
    logic [1:0]        wr_state, wr_state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len, wr_cnt;
    logic [1:0]        wr_burst;
    logic              wr_fire;

    assign wr_fire = W_VALID && (wr_state == WS_DATA);

    always_ff @(posedge CLK) begin
        if (RST) wr_state <= WS_IDLE;
        else     wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WS_IDLE: if (W_START) wr_state_nxt = WS_DATA;
            WS_DATA: if (wr_fire && wr_cnt == wr_len) wr_state_nxt = WS_RESP;
            WS_RESP: wr_state_nxt = WS_IDLE;
            default: wr_state_nxt = WS_IDLE;
        endcase
    end

    always_comb begin
        W_READY = (wr_state == WS_DATA);
        W_BUSY  = (wr_state == WS_DATA);
        W_DONE  = (wr_state == WS_RESP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_burst <= '0;
        end else if (wr_state == WS_IDLE && W_START) begin
            wr_addr  <= W_ADDR;
            wr_len   <= W_LEN;
            wr_cnt   <= '0;
            wr_burst <= W_BURST;
        end else if (wr_fire) begin
            wr_addr <= next_addr(wr_addr, wr_len, wr_burst);
            wr_cnt  <= wr_cnt + 1'b1;
        end
    end

    // Storage is never reset; a beat coinciding with RST is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && wr_fire) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (W_STRB[i])
                    mem[wr_addr + ADDR_W'(i)] <= W_DATA[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    logic [1:0]              rd_state, rd_state_nxt;
    logic [ADDR_W-1:0]       rd_addr;
    logic [LEN_W-1:0]        rd_len, rd_cnt;
    logic [1:0]              rd_burst;
    logic [8*DATA_BYTES-1:0] rd_data;
    logic                    rd_last_beat, rd_load;

    assign rd_last_beat = (rd_cnt == rd_len);
    // Reload on fetch or on a handshake with beats left: no bubble between beats.
    assign rd_load = (rd_state == RS_FETCH) ||
                     (rd_state == RS_OUT && R_READY && !rd_last_beat);

    always_ff @(posedge CLK) begin
        if (RST) rd_state <= RS_IDLE;
        else     rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RS_IDLE:  if (R_START) rd_state_nxt = RS_FETCH;
            RS_FETCH: rd_state_nxt = RS_OUT;
            RS_OUT:   if (R_READY && rd_last_beat) rd_state_nxt = RS_IDLE;
            default:  rd_state_nxt = RS_IDLE;
        endcase
    end

    always_comb begin
        R_VALID = (rd_state == RS_OUT);
        R_LAST  = (rd_state == RS_OUT) && rd_last_beat;
        R_BUSY  = (rd_state != RS_IDLE);
        R_DATA  = rd_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_burst <= '0;
            rd_data  <= '0;
        end else begin
            if (rd_state == RS_IDLE && R_START) begin
                rd_addr  <= R_ADDR;
                rd_len   <= R_LEN;
                rd_cnt   <= '0;
                rd_burst <= R_BURST;
            end
            if (rd_load) begin
                for (int i = 0; i < DATA_BYTES; i++)
                    rd_data[8*i +: 8] <= mem[rd_addr + ADDR_W'(i)];
                rd_addr <= next_addr(rd_addr, rd_len, rd_burst);
                if (rd_state == RS_OUT)
                    rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_ram.md
# mem_burst_ram

Parametrised, byte-addressed single-port-per-direction RAM with independent read and write burst engines. Each engine takes a start command carrying address, beat count and burst type, then streams DATA_BYTES-wide beats over a valid/ready handshake. Storage is little-endian byte lanes with per-byte write strobes and modulo-DEPTH address wrap. It sits behind the AXI slave front end as its backing store and replaces the fixed 32-bit, 128-byte memory.

## Interface
- DATA_BYTES, 4: bytes per beat; data width is 8*DATA_BYTES.
- ADDR_W, 7: byte-address width; DEPTH = 2^ADDR_W bytes.
- LEN_W, 8: width of the beat-count field; a burst is LEN+1 beats.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- W_START  in  1  write command strobe; accepted only when W_BUSY=0.
- W_ADDR  in  ADDR_W  write start byte address.
- W_LEN  in  LEN_W  write beats minus one.
- W_BURST  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 treated as INCR.
- W_VALID  in  1  write beat valid.
- W_DATA  in  8*DATA_BYTES  write beat; lane i targets byte addr+i.
- W_STRB  in  DATA_BYTES  per-lane write enable.
- W_READY  out  1  engine accepts a write beat.
- W_BUSY  out  1  write command in progress.
- W_DONE  out  1  one-cycle pulse after the last write beat.
- R_START  in  1  read command strobe; accepted only when R_BUSY=0.
- R_ADDR  in  ADDR_W  read start byte address.
- R_LEN  in  LEN_W  read beats minus one.
- R_BURST  in  2  read burst type, same encoding as W_BURST.
- R_READY  in  1  consumer accepts a read beat.
- R_DATA  out  8*DATA_BYTES  read beat; lane i = byte at addr+i.
- R_VALID  out  1  R_DATA holds a valid beat.
- R_LAST  out  1  current read beat is the final one.
- R_BUSY  out  1  read command in progress.

## Operation
- Storage is DEPTH bytes. Contents are unaffected by RST and are X/undefined after power-up unless preloaded by the bench.
- Byte address arithmetic is modulo DEPTH. A beat at addr touches bytes (addr+i) mod DEPTH for i in 0..DATA_BYTES-1. Unaligned addresses are legal.
- Next-beat address rules:
  - FIXED: the address does not change.
  - INCR: addr += DATA_BYTES, mod DEPTH.
  - WRAP: the wrap window is (LEN+1)*DATA_BYTES bytes, aligned to a multiple of its size; the address increments and wraps to the window base.
  - WRAP with LEN not in {1,3,7,15} behaves as INCR.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - In W_IDLE, W_START latches the command and moves to W_DATA.
  - In W_DATA, W_READY=1. Each W_VALID&&W_READY writes lanes with W_STRB[i]=1 and advances the address and beat counter.
  - The handshake on beat LEN moves the FSM to W_RESP.
  - W_RESP drives W_DONE=1 for one cycle, then returns to W_IDLE.
- Read FSM: R_IDLE -> R_FETCH -> R_OUT -> R_IDLE.
  - In R_IDLE, R_START latches the command and moves to R_FETCH.
  - R_FETCH registers beat 0 into R_DATA and moves to R_OUT.
  - In R_OUT, R_VALID=1. R_DATA, R_VALID and R_LAST hold stable while R_READY=0.
  - On R_VALID&&R_READY with beats remaining, the next beat is registered in the same edge, so R_VALID stays high with no bubble.
  - On the handshake of beat LEN, the FSM returns to R_IDLE.
- The two engines are fully independent and may run concurrently.
- Same-edge read register load and write to the same byte: the read captures the OLD byte (read-first).
- W_START while W_BUSY=1, or R_START while R_BUSY=1, is ignored.
- RST in any state:
  - Both FSMs go to IDLE.
  - The in-flight burst is abandoned; bytes already written stay written.
  - All outputs take their reset values on the next edge.

## Timing
- Reset values: W_READY=0, W_BUSY=0, W_DONE=0, R_VALID=0, R_LAST=0, R_BUSY=0, R_DATA=0.
- Write:
  - W_BUSY and W_READY rise the cycle after W_START.
  - Each accepted beat is visible in storage after that edge.
  - W_DONE pulses the cycle after the last beat handshake, and W_BUSY falls with it.
  - Minimum command-to-command spacing is LEN+3 cycles.
- Read:
  - R_BUSY rises the cycle after R_START.
  - R_VALID rises 2 cycles after R_START, giving first-beat latency 2.
  - At full throughput, beats stream at one per cycle.
  - R_BUSY, R_VALID and R_LAST fall the cycle after the last handshake.
  - A new R_START is legal in that same cycle.
- LEN=0 is a single beat: R_LAST=1 on that beat; W_DONE pulses one cycle after its handshake.

## Test plan
- Reset, then preload bytes 0x00..0x7F with their address values. Read INCR, addr 0, LEN 3, R_READY=1 -> R_DATA 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles; R_LAST only on the 4th beat; first R_VALID 2 cycles after R_START.
- Write INCR at addr 0x7E, LEN 0, data 0xAABBCCDD, strobe 4'b1111, then read the same address -> bytes 0x7E=DD, 0x7F=CC, 0x00=BB, 0x01=AA (modulo wrap); W_DONE pulses exactly once.
- Write strobe 4'b0101 with 0x11223344 to addr 0x10 over the preloaded pattern -> read returns 0x13221144.
- Read WRAP, addr 0x08, LEN 3 -> beats from addresses 0x08, 0x0C, 0x00, 0x04. Throttle R_READY low for 3 cycles mid-burst -> R_DATA holds stable and no beat is lost or duplicated.
- Run concurrent read and write of the same word: write 0xFFFFFFFF to addr 0x20 on the same edge the read registers addr 0x20 -> the read returns the old 0x23222120, and a subsequent read returns 0xFFFFFFFF.
- Assert RST mid-burst (write beat 2 of 4, read beat 1 of 4) -> next cycle all outputs are at reset values, beats 0-1 of the write persist, and a fresh R_START completes normally.
